// File: rtl/sobel_window_ctrl_if.sv
// Bundle of the pixel-source, sobel-engine and edge-writer signals around sobel_window_ctrl.
// master = the controller side, slave = the surrounding environment.
interface sobel_window_ctrl_if;
   logic                  start;
   logic [7:0]            pixel_in;
   logic                  pixel_valid;
   logic                  pixel_ready;
   logic [2:0][2:0][7:0]  comp_matrix;
   logic                  sobel_en;
   logic                  output_pixel;
   logic                  sobel_done;
   logic [7:0]            edge_byte;
   logic                  edge_valid;
   logic                  edge_ready;
   logic                  busy;
   logic                  frame_done;

   modport master (
      input  start, pixel_in, pixel_valid, output_pixel, sobel_done, edge_ready,
      output pixel_ready, comp_matrix, sobel_en, edge_byte, edge_valid, busy, frame_done
   );

   modport slave (
      output start, pixel_in, pixel_valid, output_pixel, sobel_done, edge_ready,
      input  pixel_ready, comp_matrix, sobel_en, edge_byte, edge_valid, busy, frame_done
   );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the combinational sobel engine: line buffers, 3x3 window,
// edge-bit packing into bytes with a single holding register and backpressure.
//
//  state   | meaning
//  S_IDLE  | waiting for start
//  S_FILL  | accepting pixels, no complete window yet
//  S_RUN   | accepting pixels, windows being presented
//  S_FLUSH | last pixel taken; drain in-flight bit, emit partial byte, wait for handshake
//  S_DONE  | one-cycle frame_done pulse
module sobel_window_ctrl #(
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic                clk,
   input  logic                n_rst,
   sobel_window_ctrl_if.master bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [7:0]           lb0_q [IMG_W];
   logic [7:0]           lb0_d [IMG_W];
   logic [7:0]           lb1_q [IMG_W];
   logic [7:0]           lb1_d [IMG_W];
   logic [2:0][2:0][7:0] win_q, win_d;
   logic                 sen_q, sen_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           bits_q, bits_d;
   logic [7:0]           ebyte_q, ebyte_d;
   logic                 evalid_q, evalid_d;

   logic                 pixel_ready;
   logic                 accept;
   logic                 last_pix;
   logic                 win_done;
   logic                 byte_taken;
   logic                 flush_load;
   logic [7:0]           bits_new;
   logic                 unused_sobel_done;

   // The engine is single-cycle, so its done flag carries no extra information.
   assign unused_sobel_done = bus.sobel_done;

   always_comb begin
      pixel_ready = ((state_q == S_FILL) || (state_q == S_RUN)) && !(evalid_q && !bus.edge_ready);
      accept      = bus.pixel_valid && pixel_ready;
      last_pix    = (col_q == COL_LAST) && (row_q == ROW_LAST);
      win_done    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      byte_taken  = evalid_q && bus.edge_ready;
      flush_load  = (state_q == S_FLUSH) && !sen_q && (bit_cnt_q != 3'd0) &&
                    (!evalid_q || bus.edge_ready);
      bits_new    = bits_q;
      bits_new[bit_cnt_q] = bus.output_pixel;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = S_FILL;
         S_FILL: begin
            if (accept && last_pix) state_d = S_FLUSH;
            else if (win_done)      state_d = S_RUN;
         end
         S_RUN:   if (accept && last_pix) state_d = S_FLUSH;
         S_FLUSH: if (!sen_q && (bit_cnt_q == 3'd0) && (!evalid_q || bus.edge_ready))
                     state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      lb0_d     = lb0_q;
      lb1_d     = lb1_q;
      win_d     = win_q;
      sen_d     = win_done;
      bit_cnt_d = bit_cnt_q;
      bits_d    = bits_q;
      ebyte_d   = ebyte_q;
      evalid_d  = evalid_q;

      if ((state_q == S_IDLE) && bus.start) begin
         col_d     = '0;
         row_d     = '0;
         bit_cnt_d = '0;
         bits_d    = '0;
      end

      if (accept) begin
         lb0_d[col_q] = lb1_q[col_q];
         lb1_d[col_q] = bus.pixel_in;
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = lb0_q[col_q];
         win_d[1][2] = lb1_q[col_q];
         win_d[2][2] = bus.pixel_in;
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (byte_taken) evalid_d = 1'b0;

      // Backpressure keeps accepts stalled while a byte waits, so a new full
      // byte can only land when the holding register is empty or being taken.
      if (sen_q) begin
         if (bit_cnt_q == 3'd7) begin
            ebyte_d   = bits_new;
            evalid_d  = 1'b1;
            bits_d    = '0;
            bit_cnt_d = '0;
         end else begin
            bits_d    = bits_new;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end else if (flush_load) begin
         ebyte_d   = bits_q;
         evalid_d  = 1'b1;
         bits_d    = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         win_q     <= '0;
         sen_q     <= 1'b0;
         bit_cnt_q <= '0;
         bits_q    <= '0;
         ebyte_q   <= '0;
         evalid_q  <= 1'b0;
         for (int i = 0; i < IMG_W; i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         win_q     <= win_d;
         sen_q     <= sen_d;
         bit_cnt_q <= bit_cnt_d;
         bits_q    <= bits_d;
         ebyte_q   <= ebyte_d;
         evalid_q  <= evalid_d;
         lb0_q     <= lb0_d;
         lb1_q     <= lb1_d;
      end
   end

   assign bus.pixel_ready = pixel_ready;
   assign bus.comp_matrix = win_q;
   assign bus.sobel_en    = sen_q;
   assign bus.edge_byte   = ebyte_q;
   assign bus.edge_valid  = evalid_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.frame_done  = (state_q == S_DONE);
endmodule
